// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) multiply helpers for the MixColumns stage.
// Build option MIXCOL_INV_EN adds the InvMixColumns constant multipliers.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam byte_t AES_POLY_RED = 8'h1B;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
    endfunction

    function automatic byte_t gmul2(input byte_t b);
        return xtime(b);
    endfunction

    function automatic byte_t gmul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

`ifdef MIXCOL_INV_EN
    function automatic byte_t gmul9(input byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic byte_t gmul11(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic byte_t gmul13(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic byte_t gmul14(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction
`endif

endpackage

// File: rtl/aes_mixcol_if.sv
// State bus between the ShiftRows stage and the MixColumns register.
// Under MIXCOL_INV_EN the bus also carries the inverse-select bit.
interface aes_mixcol_if;
    import aes_pkg::*;

    state_t in;
    state_t out;
`ifdef MIXCOL_INV_EN
    logic   inv;

    modport master (output in, output inv, input out);
    modport slave  (input in, input inv, output out);
`else
    modport master (output in, input out);
    modport slave  (input in, output out);
`endif

endinterface

// File: rtl/aes_mixcol_column.sv
// Combinational MixColumns transform of one 32-bit column (top row in [31:24]).
// Under MIXCOL_INV_EN the inv input selects InvMixColumns.
module aes_mixcol_column
    import aes_pkg::*;
(
    input  word_t col_in,
`ifdef MIXCOL_INV_EN
    input  logic  inv,
`endif
    output word_t col_out
);

    byte_t s0_s, s1_s, s2_s, s3_s;
    byte_t r0_s, r1_s, r2_s, r3_s;

    assign s0_s = col_in[31:24];
    assign s1_s = col_in[23:16];
    assign s2_s = col_in[15:8];
    assign s3_s = col_in[7:0];

    // Column matrix product; each output row is the previous row rotated right
    always_comb begin
        r0_s = gmul2(s0_s) ^ gmul3(s1_s) ^ s2_s ^ s3_s;
        r1_s = s0_s ^ gmul2(s1_s) ^ gmul3(s2_s) ^ s3_s;
        r2_s = s0_s ^ s1_s ^ gmul2(s2_s) ^ gmul3(s3_s);
        r3_s = gmul3(s0_s) ^ s1_s ^ s2_s ^ gmul2(s3_s);
`ifdef MIXCOL_INV_EN
        if (inv) begin
            r0_s = gmul14(s0_s) ^ gmul11(s1_s) ^ gmul13(s2_s) ^ gmul9(s3_s);
            r1_s = gmul9(s0_s) ^ gmul14(s1_s) ^ gmul11(s2_s) ^ gmul13(s3_s);
            r2_s = gmul13(s0_s) ^ gmul9(s1_s) ^ gmul14(s2_s) ^ gmul11(s3_s);
            r3_s = gmul11(s0_s) ^ gmul13(s1_s) ^ gmul9(s2_s) ^ gmul14(s3_s);
        end else begin
            r0_s = gmul2(s0_s) ^ gmul3(s1_s) ^ s2_s ^ s3_s;
            r1_s = s0_s ^ gmul2(s1_s) ^ gmul3(s2_s) ^ s3_s;
            r2_s = s0_s ^ s1_s ^ gmul2(s2_s) ^ gmul3(s3_s);
            r3_s = gmul3(s0_s) ^ s1_s ^ s2_s ^ gmul2(s3_s);
        end
`endif
    end

    assign col_out = {r0_s, r1_s, r2_s, r3_s};

endmodule

// File: rtl/aes_mixcol.sv
// AES MixColumns round stage: four column transforms feeding one 128-bit register.
// Define MIXCOL_INV_EN to add the inv select for InvMixColumns.
module aes_mixcol
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    aes_mixcol_if.slave  bus
);

    state_t mixed_s;
    state_t out_r;

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_mixcol_column u_col (
            .col_in  (bus.in[127-32*c -: 32]),
`ifdef MIXCOL_INV_EN
            .inv     (bus.inv),
`endif
            .col_out (mixed_s[127-32*c -: 32])
        );
    end

    // Output register loads every cycle; reset clears it asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= 128'h0;
        end else begin
            out_r <= mixed_s;
        end
    end

    assign bus.out = out_r;

endmodule

// File: tb/tb_aes_mixcol.sv
// Scoreboard bench for aes_mixcol: GF(2^8) matrix reference model, known vectors,
// random back-to-back traffic and asynchronous reset checks. Honours MIXCOL_INV_EN.
module tb_aes_mixcol;
    import aes_pkg::*;

`ifdef MIXCOL_INV_EN
    localparam bit INV_AVAIL = 1'b1;
`else
    localparam bit INV_AVAIL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_mixcol_if bus ();

    aes_mixcol dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        state_t exp;
        int     id;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   next_id = 0;

    // Generic shift-and-add GF(2^8) product, reduction polynomial 0x11B
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        byte_t y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            if (x[7]) x = (x << 1) ^ 8'h1B;
            else      x = x << 1;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic state_t ref_mix(input state_t s, input bit inv_v);
        byte_t  base[4];
        byte_t  acc;
        state_t r = 128'h0;
        if (inv_v) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else       base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(base[(j - row + 4) % 4], s[127-8*(4*c+j) -: 8]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic apply(input state_t v, input bit inv_v);
        bus.in = v;
`ifdef MIXCOL_INV_EN
        bus.inv = inv_v;
`endif
    endtask

    task automatic apply_push(input state_t v, input bit inv_v, input state_t exp);
        exp_t e;
        apply(v, inv_v);
        e.exp = exp;
        e.id  = next_id;
        next_id++;
        sb_q.push_back(e);
    endtask

    task automatic drive_exp(input state_t v, input bit inv_v, input state_t exp);
        @(negedge clk);
        apply_push(v, inv_v, exp);
    endtask

    task automatic drive(input state_t v, input bit inv_v);
        bit eff;
        eff = inv_v & INV_AVAIL;
        @(negedge clk);
        apply_push(v, eff, ref_mix(v, eff));
    endtask

    task automatic cmp(input string name, input state_t act, input state_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: out=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per loading edge
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (bus.out !== e.exp) begin
                n_bad++;
                $display("FAIL vec%0d: out=%h expected=%h", e.id, bus.out, e.exp);
            end
        end
    end

    initial begin
        state_t v;
        int     t;

        rst_n = 1'b0;
        apply(128'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_out", bus.out, 128'h0);

        @(negedge clk);
        rst_n = 1'b1;
        apply_push(128'h6353e08c0960e104cd70b751bacad0e7, 1'b0,
                   128'h5f72641557f5bc92f7be3b291db9f91a);
        drive_exp({4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
        drive_exp({4{32'hf20a225c}}, 1'b0, {4{32'h9fdc589d}});
        drive_exp({4{32'h2d26314c}}, 1'b0, {4{32'h4d7ebdf8}});
        drive_exp({4{32'h01010101}}, 1'b0, {4{32'h01010101}});
        drive_exp({4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}});
        drive_exp({4{32'hd4d4d4d5}}, 1'b0, {4{32'hd5d5d7d6}});
        drive_exp({32'h0, 32'hdb135345, 32'h0, 32'h2d26314c}, 1'b0,
                  {32'h0, 32'h8e4da1bc, 32'h0, 32'h4d7ebdf8});
`ifdef MIXCOL_INV_EN
        drive_exp(128'h5f72641557f5bc92f7be3b291db9f91a, 1'b1,
                  128'h6353e08c0960e104cd70b751bacad0e7);
        drive_exp({4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}});
`endif

        for (int i = 0; i < 40; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            drive(v, 1'($urandom_range(0, 1)));
        end
        drive_exp({4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}});

        // Asynchronous clear between edges while the output holds c6..c6
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        cmp("async_reset", bus.out, 128'h0);
        @(posedge clk);
        #1;
        cmp("reset_hold", bus.out, 128'h0);

        @(negedge clk);
        rst_n = 1'b1;
        apply_push(128'h6353e08c0960e104cd70b751bacad0e7, 1'b0,
                   128'h5f72641557f5bc92f7be3b291db9f91a);
        drive({4{32'hf20a225c}}, 1'b0);

        // Mid-stream reset: the applied input must never reach the output
        @(negedge clk);
        apply({4{32'hdb135345}}, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("midstream_async", bus.out, 128'h0);
        @(posedge clk);
        #1;
        cmp("midstream_discard", bus.out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_push({4{32'h2d26314c}}, 1'b0, {4{32'h4d7ebdf8}});

        t = 0;
        while (sb_q.size() > 0 && t < 10) begin
            @(posedge clk);
            t++;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
